// File: rtl/sram_write_buffer.sv
// ---------------------------------------------------------------------------
// sram_write_buffer
//
// Posted-write buffer between the cache controller (upstream) and the SRAM
// controller (downstream). Cache write-throughs are absorbed into a small FIFO
// and drained to SRAM in order. Reads bypass buffered writes unless they hit
// a 64-bit block that still has a pending write. In that case the read waits
// until those writes have drained.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   req_rd / req_wr   upstream read / write request (read held until ready)
//   req_addr          upstream byte address
//   req_wdata         upstream write data
//   req_ready         write accepted (combinational, same cycle) or
//                     read data valid (one-cycle pulse)
//   req_rdata         64-bit block returned by the last read
//   sram_rd_en        read command to the SRAM controller
//   sram_wr_en        write command to the SRAM controller
//   sram_address      command address
//   sram_write_data   command write data
//   sram_ready        SRAM command-complete pulse
//   sram_read_data    SRAM read block, valid with sram_ready
//   count             occupied FIFO entries
//   full / empty      count == DEPTH / count == 0
// ---------------------------------------------------------------------------
module sram_write_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_rd,
   input  logic                   req_wr,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [DATA_W-1:0]      req_wdata,
   output logic                   req_ready,
   output logic [63:0]            req_rdata,
   output logic                   sram_rd_en,
   output logic                   sram_wr_en,
   output logic [ADDR_W-1:0]      sram_address,
   output logic [DATA_W-1:0]      sram_write_data,
   input  logic                   sram_ready,
   input  logic [63:0]            sram_read_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_t;

   state_t state_reg, state_next;

   // Entries live in registers rather than block RAM because every entry is
   // compared against the read address in the same cycle.
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic              rd_done_reg;
   logic [63:0]       rdata_reg;
   logic [DEPTH-1:0]  block_match;

   logic push;
   logic pop;
   logic conflict;
   logic full_int;
   logic empty_int;

   genvar gi;

   assign full_int  = (count_reg == CNT_W'(DEPTH));
   assign empty_int = (count_reg == '0);

   // Fullness is judged on the registered count. A pop on the same edge
   // therefore cannot make room for this cycle's push.
   assign push = req_wr & ~full_int;
   // The head entry stays valid and visible until its write completes.
   assign pop  = (state_reg == WRITE) & sram_ready;

   // ------------------------------------------------------------------
   // Entry storage. The data path needs no reset because the per-entry
   // valid flags gate every use of it.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_reg] <= req_addr;
         data_mem[wr_ptr_reg] <= req_wdata;
      end
   end

   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic entry_valid_reg;

         // Push and pop never target the same slot in one cycle. A push
         // needs a non-full FIFO, and a pop needs a non-empty one.
         always_ff @(posedge clk) begin
            if (rst) begin
               entry_valid_reg <= 1'b0;
            end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
               entry_valid_reg <= 1'b1;
            end else if (pop && (rd_ptr_reg == PTR_W'(gi))) begin
               entry_valid_reg <= 1'b0;
            end
         end

         // Compare at 64-bit block granularity (ignore byte-in-block bits).
         assign block_match[gi] = entry_valid_reg &&
            (addr_mem[gi][ADDR_W-1:3] == req_addr[ADDR_W-1:3]);
      end
   endgenerate

   assign conflict = req_rd & (|block_match);

   // ------------------------------------------------------------------
   // Pointers and occupancy
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Read return. Data is registered, so the ready pulse is registered
   // with it and coincides with valid req_rdata.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_done_reg <= 1'b0;
         rdata_reg   <= '0;
      end else begin
         rd_done_reg <= (state_reg == READ) & sram_ready;
         if ((state_reg == READ) && sram_ready) begin
            rdata_reg <= sram_read_data;
         end
      end
   end

   // ------------------------------------------------------------------
   // Command FSM: one SRAM command outstanding at a time. Every command
   // returns to IDLE, which guarantees a cycle with both enables low.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      sram_wr_en      = 1'b0;
      sram_rd_en      = 1'b0;
      sram_address    = addr_mem[rd_ptr_reg];
      sram_write_data = data_mem[rd_ptr_reg];
      case (state_reg)
         IDLE: begin
            // A read that just completed is still held by the requester
            // during its ready pulse, so it must not be re-issued. A read
            // that comes with a write is ignored.
            if (req_rd && !req_wr && !conflict && !rd_done_reg) begin
               state_next = READ;
            end else if (!empty_int) begin
               state_next = WRITE;
            end
         end
         WRITE: begin
            sram_wr_en = 1'b1;
            if (sram_ready) begin
               state_next = IDLE;
            end
         end
         READ: begin
            sram_rd_en   = 1'b1;
            sram_address = req_addr;
            if (sram_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign req_ready = push | rd_done_reg;
   assign req_rdata = rdata_reg;
   assign count     = count_reg;
   assign full      = full_int;
   assign empty     = empty_int;

endmodule

// File: tb/tb_sram_write_buffer.sv
// ---------------------------------------------------------------------------
// tb_sram_write_buffer
//
// Directed scenarios for reset, single write, full handling, read bypass,
// read conflict and same-address ordering. A randomized traffic phase checks
// the DUT against a queue and memory reference model. The bench also acts as
// the SRAM controller, which responds with random latency.
// ---------------------------------------------------------------------------
module tb_sram_write_buffer;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   req_rd;
   logic                   req_wr;
   logic [ADDR_W-1:0]      req_addr;
   logic [DATA_W-1:0]      req_wdata;
   logic                   req_ready;
   logic [63:0]            req_rdata;
   logic                   sram_rd_en;
   logic                   sram_wr_en;
   logic [ADDR_W-1:0]      sram_address;
   logic [DATA_W-1:0]      sram_write_data;
   logic                   sram_ready;
   logic [63:0]            sram_read_data;
   logic [$clog2(DEPTH):0] count;
   logic                   full;
   logic                   empty;

   int n_cmp = 0;
   int n_err = 0;

   // Model state used by the scenarios
   logic [31:0] fa [5];
   logic [31:0] fd [5];
   logic [31:0] qa [$];
   logic [31:0] qd [$];
   logic [63:0] mem [bit [28:0]];

   always #5 clk = ~clk;

   sram_write_buffer #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_rd         (req_rd),
      .req_wr         (req_wr),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_ready      (req_ready),
      .req_rdata      (req_rdata),
      .sram_rd_en     (sram_rd_en),
      .sram_wr_en     (sram_wr_en),
      .sram_address   (sram_address),
      .sram_write_data(sram_write_data),
      .sram_ready     (sram_ready),
      .sram_read_data (sram_read_data),
      .count          (count),
      .full           (full),
      .empty          (empty)
   );

   // Inputs change 1 time unit after the rising edge. Outputs are sampled on
   // the falling edge, or at posedge+1 for state-only outputs.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      req_rd         = 1'b0;
      req_wr         = 1'b0;
      req_addr       = '0;
      req_wdata      = '0;
      sram_ready     = 1'b0;
      sram_read_data = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // One write offer for one cycle. Reports whether req_ready was seen.
   task automatic drive_write(input logic [31:0] a, input logic [31:0] d, output logic acc);
      req_rd    = 1'b0;
      req_wr    = 1'b1;
      req_addr  = a;
      req_wdata = d;
      @(negedge clk);
      acc = req_ready;
      tick();
      req_wr = 1'b0;
   endtask

   task automatic pulse_ready(input logic [63:0] d);
      sram_ready     = 1'b1;
      sram_read_data = d;
      tick();
      sram_ready     = 1'b0;
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      logic acc;
      logic all_acc;
      logic stale;
      do_reset();
      @(negedge clk);
      n_cmp++;
      if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
         n_err++;
         $display("FAIL reset_occupancy: got count=%0d empty=%0b full=%0b want 0/1/0", count, empty, full);
      end
      n_cmp++;
      if (sram_wr_en !== 1'b0 || sram_rd_en !== 1'b0) begin
         n_err++;
         $display("FAIL reset_enables: got wr=%0b rd=%0b want 0/0", sram_wr_en, sram_rd_en);
      end
      n_cmp++;
      if (req_ready !== 1'b0 || req_rdata !== 64'h0) begin
         n_err++;
         $display("FAIL reset_req: got ready=%0b rdata=%h want 0/0", req_ready, req_rdata);
      end
      tick();
      all_acc = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_write(32'h0000_0800 + 32'(i * 8), $urandom, acc);
         all_acc &= acc;
      end
      @(negedge clk);
      n_cmp++;
      if (all_acc !== 1'b1 || sram_wr_en !== 1'b1 || count !== 3'd3) begin
         n_err++;
         $display("FAIL reset_setup: got acc=%0b wr_en=%0b count=%0d want 1/1/3", all_acc, sram_wr_en, count);
      end
      tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      n_cmp++;
      if (count !== 3'd0 || empty !== 1'b1 || sram_wr_en !== 1'b0) begin
         n_err++;
         $display("FAIL reset_midwrite: got count=%0d empty=%0b wr_en=%0b want 0/1/0", count, empty, sram_wr_en);
      end
      tick();
      rst   = 1'b0;
      stale = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sram_ready = (i % 2 == 0);
         @(negedge clk);
         if (sram_wr_en !== 1'b0 || count !== 3'd0) stale = 1'b1;
         tick();
      end
      sram_ready = 1'b0;
      n_cmp++;
      if (stale !== 1'b0) begin
         n_err++;
         $display("FAIL reset_stale: got stale activity=%0b want 0", stale);
      end
      $display("test_reset done");
   endtask

   // ------------------------------------------------------------------
   task automatic test_single_write();
      logic acc;
      do_reset();
      drive_write(32'h0000_0100, 32'hDEAD_BEEF, acc);
      @(negedge clk);
      n_cmp++;
      if (acc !== 1'b1 || count !== 3'd1 || sram_wr_en !== 1'b0) begin
         n_err++;
         $display("FAIL single_accept: got ready=%0b count=%0d wr_en=%0b want 1/1/0", acc, count, sram_wr_en);
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (sram_wr_en !== 1'b1 || sram_address !== 32'h100 || sram_write_data !== 32'hDEAD_BEEF) begin
         n_err++;
         $display("FAIL single_cmd: got en=%0b addr=%h data=%h want 1/00000100/deadbeef", sram_wr_en, sram_address, sram_write_data);
      end
      tick();
      repeat (3) tick();
      @(negedge clk);
      n_cmp++;
      if (sram_wr_en !== 1'b1 || sram_address !== 32'h100 || sram_write_data !== 32'hDEAD_BEEF) begin
         n_err++;
         $display("FAIL single_hold: got en=%0b addr=%h data=%h want stable command", sram_wr_en, sram_address, sram_write_data);
      end
      tick();
      pulse_ready(64'h0);
      @(negedge clk);
      n_cmp++;
      if (count !== 3'd0 || empty !== 1'b1 || sram_wr_en !== 1'b0) begin
         n_err++;
         $display("FAIL single_done: got count=%0d empty=%0b wr_en=%0b want 0/1/0", count, empty, sram_wr_en);
      end
      tick();
      $display("test_single_write: addr=00000100 data=deadbeef");
   endtask

   // ------------------------------------------------------------------
   task automatic test_full();
      logic acc;
      logic all_acc;
      int   t;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         fa[i] = 32'h0000_2000 + 32'(i * 16);
         fd[i] = $urandom;
      end
      all_acc = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_write(fa[i], fd[i], acc);
         all_acc &= acc;
      end
      @(negedge clk);
      n_cmp++;
      if (all_acc !== 1'b1 || full !== 1'b1 || count !== 3'd4) begin
         n_err++;
         $display("FAIL full_fill: got acc=%0b full=%0b count=%0d want 1/1/4", all_acc, full, count);
      end
      tick();
      req_wr    = 1'b1;
      req_addr  = fa[4];
      req_wdata = fd[4];
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b0 || sram_address !== fa[0]) begin
         n_err++;
         $display("FAIL full_reject: got ready=%0b head=%h want 0/%h", req_ready, sram_address, fa[0]);
      end
      tick();
      sram_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b0) begin
         n_err++;
         $display("FAIL full_same_cycle_pop: got ready=%0b want 0", req_ready);
      end
      tick();
      sram_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1 || count !== 3'd3) begin
         n_err++;
         $display("FAIL full_after_pop: got ready=%0b count=%0d want 1/3", req_ready, count);
      end
      tick();
      req_wr = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (count !== 3'd4 || full !== 1'b1) begin
         n_err++;
         $display("FAIL full_refill: got count=%0d full=%0b want 4/1", count, full);
      end
      tick();
      for (int k = 1; k < 5; k++) begin
         t = 0;
         while (sram_wr_en !== 1'b1 && t < 20) begin
            tick();
            t++;
         end
         n_cmp++;
         if (sram_wr_en !== 1'b1 || sram_address !== fa[k] || sram_write_data !== fd[k]) begin
            n_err++;
            $display("FAIL full_drain[%0d]: got en=%0b addr=%h data=%h want 1/%h/%h", k, sram_wr_en, sram_address, sram_write_data, fa[k], fd[k]);
         end else begin
            $display("test_full: drained addr=%h data=%h", sram_address, sram_write_data);
         end
         pulse_ready(64'h0);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_read_bypass();
      logic acc;
      int   t;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         fa[i] = 32'h0000_0200 + 32'(i * 4);
         fd[i] = $urandom;
         drive_write(fa[i], fd[i], acc);
      end
      req_rd   = 1'b1;
      req_addr = 32'h0000_0400;
      @(negedge clk);
      n_cmp++;
      if (sram_wr_en !== 1'b1 || sram_address !== 32'h200) begin
         n_err++;
         $display("FAIL bypass_inflight: got en=%0b addr=%h want 1/00000200", sram_wr_en, sram_address);
      end
      tick();
      pulse_ready(64'h0);
      @(negedge clk);
      n_cmp++;
      if (sram_wr_en !== 1'b0 || sram_rd_en !== 1'b0) begin
         n_err++;
         $display("FAIL bypass_gap: got wr=%0b rd=%0b want 0/0", sram_wr_en, sram_rd_en);
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (sram_rd_en !== 1'b1 || sram_wr_en !== 1'b0 || sram_address !== 32'h400 || count !== 3'd2) begin
         n_err++;
         $display("FAIL bypass_read: got rd=%0b wr=%0b addr=%h count=%0d want 1/0/00000400/2", sram_rd_en, sram_wr_en, sram_address, count);
      end
      tick();
      pulse_ready(64'h1122_3344_5566_7788);
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1 || req_rdata !== 64'h1122_3344_5566_7788) begin
         n_err++;
         $display("FAIL bypass_data: got ready=%0b rdata=%h want 1/1122334455667788", req_ready, req_rdata);
      end
      tick();
      req_rd = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b0) begin
         n_err++;
         $display("FAIL bypass_pulse: got ready=%0b want 0", req_ready);
      end
      tick();
      for (int k = 1; k < 3; k++) begin
         t = 0;
         while (sram_wr_en !== 1'b1 && t < 20) begin
            tick();
            t++;
         end
         n_cmp++;
         if (sram_wr_en !== 1'b1 || sram_address !== fa[k] || sram_write_data !== fd[k]) begin
            n_err++;
            $display("FAIL bypass_drain[%0d]: got en=%0b addr=%h data=%h want 1/%h/%h", k, sram_wr_en, sram_address, sram_write_data, fa[k], fd[k]);
         end
         pulse_ready(64'h0);
      end
      $display("test_read_bypass: read 00000400 returned 1122334455667788");
   endtask

   // ------------------------------------------------------------------
   task automatic test_read_conflict();
      logic        acc;
      logic [63:0] rd;
      do_reset();
      drive_write(32'h0000_00F0, $urandom, acc);
      drive_write(32'h0000_0108, 32'hA5A5_0108, acc);
      drive_write(32'h0000_0300, 32'h5A5A_0300, acc);
      req_rd   = 1'b1;
      req_addr = 32'h0000_010C;
      pulse_ready(64'h0);
      tick();
      @(negedge clk);
      n_cmp++;
      if (sram_wr_en !== 1'b1 || sram_rd_en !== 1'b0 || sram_address !== 32'h108) begin
         n_err++;
         $display("FAIL conflict_blocks: got wr=%0b rd=%0b addr=%h want 1/0/00000108", sram_wr_en, sram_rd_en, sram_address);
      end
      tick();
      pulse_ready(64'h0);
      tick();
      @(negedge clk);
      n_cmp++;
      if (sram_rd_en !== 1'b1 || sram_address !== 32'h10C || count !== 3'd1) begin
         n_err++;
         $display("FAIL conflict_read: got rd=%0b addr=%h count=%0d want 1/0000010c/1", sram_rd_en, sram_address, count);
      end
      rd = {$urandom, $urandom};
      tick();
      pulse_ready(rd);
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1 || req_rdata !== rd) begin
         n_err++;
         $display("FAIL conflict_data: got ready=%0b rdata=%h want 1/%h", req_ready, req_rdata, rd);
      end
      tick();
      req_rd = 1'b0;
      tick();
      @(negedge clk);
      n_cmp++;
      if (sram_wr_en !== 1'b1 || sram_address !== 32'h300 || sram_write_data !== 32'h5A5A_0300) begin
         n_err++;
         $display("FAIL conflict_tail: got en=%0b addr=%h data=%h want 1/00000300/5a5a0300", sram_wr_en, sram_address, sram_write_data);
      end
      tick();
      pulse_ready(64'h0);
      $display("test_read_conflict: read 0000010c returned %h", rd);
   endtask

   // ------------------------------------------------------------------
   task automatic test_ordering();
      logic        acc;
      logic [63:0] rd;
      do_reset();
      drive_write(32'h0000_0050, 32'd1, acc);
      drive_write(32'h0000_0050, 32'd2, acc);
      req_rd   = 1'b1;
      req_addr = 32'h0000_0050;
      @(negedge clk);
      n_cmp++;
      if (sram_wr_en !== 1'b1 || sram_address !== 32'h50 || sram_write_data !== 32'd1) begin
         n_err++;
         $display("FAIL order_first: got en=%0b addr=%h data=%0d want 1/00000050/1", sram_wr_en, sram_address, sram_write_data);
      end
      tick();
      pulse_ready(64'h0);
      tick();
      @(negedge clk);
      n_cmp++;
      if (sram_wr_en !== 1'b1 || sram_rd_en !== 1'b0 || sram_write_data !== 32'd2) begin
         n_err++;
         $display("FAIL order_second: got wr=%0b rd=%0b data=%0d want 1/0/2", sram_wr_en, sram_rd_en, sram_write_data);
      end
      tick();
      pulse_ready(64'h0);
      tick();
      @(negedge clk);
      n_cmp++;
      if (sram_rd_en !== 1'b1 || sram_address !== 32'h50 || count !== 3'd0) begin
         n_err++;
         $display("FAIL order_read: got rd=%0b addr=%h count=%0d want 1/00000050/0", sram_rd_en, sram_address, count);
      end
      rd = {32'd0, 32'd2};
      tick();
      pulse_ready(rd);
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1 || req_rdata !== rd) begin
         n_err++;
         $display("FAIL order_data: got ready=%0b rdata=%h want 1/%h", req_ready, req_rdata, rd);
      end
      tick();
      req_rd = 1'b0;
      tick();
      $display("test_ordering: 0x50 written 1 then 2, read after both");
   endtask

   // ------------------------------------------------------------------
   // Randomized traffic. The model is a FIFO queue of posted writes plus a
   // block memory updated when a write completes. The bench plays the SRAM
   // controller with random completion latency.
   task automatic test_random_traffic();
      int          op;           // 0 none, 1 write offered, 2 read held
      int          busy;
      int          lat;
      int          is_rd;
      int          wait_cnt;
      int unsigned r;
      logic        just_completed;
      logic        wr_completes;
      logic        rd_done_now;
      logic        rd_done_next;
      logic        exp_ready;
      logic        release_req;
      logic        found;
      logic [63:0] exp_rdata;
      logic [63:0] v;
      logic [28:0] blk;
      do_reset();
      qa.delete();
      qd.delete();
      mem.delete();
      op = 0; busy = 0; lat = 0; is_rd = 0; wait_cnt = 0;
      just_completed = 1'b0;
      rd_done_next   = 1'b0;
      exp_rdata      = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (just_completed) begin
            n_cmp++;
            if (sram_wr_en !== 1'b0 || sram_rd_en !== 1'b0) begin
               n_err++;
               $display("FAIL rnd_idle_gap: got wr=%0b rd=%0b want 0/0 (cycle %0d)", sram_wr_en, sram_rd_en, cyc);
            end
         end
         just_completed = 1'b0;
         wr_completes   = 1'b0;
         rd_done_now    = rd_done_next;
         rd_done_next   = 1'b0;
         sram_ready     = 1'b0;
         if (busy == 0 && (sram_wr_en === 1'b1 || sram_rd_en === 1'b1)) begin
            if (sram_wr_en === 1'b1) begin
               n_cmp++;
               if (qa.size() == 0 || sram_address !== qa[0] || sram_write_data !== qd[0]) begin
                  n_err++;
                  $display("FAIL rnd_wr_order: got addr=%h data=%h want head of %0d posted writes", sram_address, sram_write_data, qa.size());
               end
               is_rd = 0;
            end else begin
               found = 1'b0;
               foreach (qa[i]) if (qa[i][31:3] == req_addr[31:3]) found = 1'b1;
               n_cmp++;
               if (found || op != 2 || sram_address !== req_addr) begin
                  n_err++;
                  $display("FAIL rnd_rd_issue: got addr=%h pending_same_block=%0b op=%0d want addr=%h no pending", sram_address, found, op, req_addr);
               end
               is_rd = 1;
            end
            busy = 1;
            lat  = int'($urandom_range(0, 3));
         end
         if (busy != 0) begin
            if (lat == 0) begin
               sram_ready = 1'b1;
               if (is_rd != 0) begin
                  blk            = req_addr[31:3];
                  exp_rdata      = mem.exists(blk) ? mem[blk] : 64'h0;
                  sram_read_data = exp_rdata;
                  rd_done_next   = 1'b1;
               end else begin
                  sram_read_data = {$urandom, $urandom};
                  wr_completes   = 1'b1;
               end
               busy           = 0;
               just_completed = 1'b1;
            end else begin
               lat--;
            end
         end
         if (op == 0) begin
            r = $urandom_range(0, 9);
            wait_cnt = 0;
            if (r < 5) begin
               op        = 1;
               req_wr    = 1'b1;
               req_addr  = 32'h0000_1000 + 32'($urandom_range(0, 7) * 4);
               req_wdata = $urandom;
            end else if (r < 7) begin
               op       = 2;
               req_rd   = 1'b1;
               req_addr = 32'h0000_1000 + 32'($urandom_range(0, 15) * 4);
            end
         end
         @(negedge clk);
         exp_ready = ((op == 1) && (qa.size() < DEPTH)) || rd_done_now;
         n_cmp++;
         if (req_ready !== exp_ready) begin
            n_err++;
            $display("FAIL rnd_ready: got %0b want %0b (cycle %0d op=%0d queued=%0d)", req_ready, exp_ready, cyc, op, qa.size());
         end
         n_cmp++;
         if (count !== qa.size() || full !== (qa.size() == DEPTH) || empty !== (qa.size() == 0)) begin
            n_err++;
            $display("FAIL rnd_count: got count=%0d full=%0b empty=%0b want count=%0d (cycle %0d)", count, full, empty, qa.size(), cyc);
         end
         if (rd_done_now) begin
            n_cmp++;
            if (req_rdata !== exp_rdata) begin
               n_err++;
               $display("FAIL rnd_rdata: got %h want %h", req_rdata, exp_rdata);
            end else begin
               $display("txn rd addr=%h data=%h", req_addr, req_rdata);
            end
         end
         release_req = 1'b0;
         if (wr_completes) begin
            blk = qa[0][31:3];
            v   = mem.exists(blk) ? mem[blk] : 64'h0;
            if (qa[0][2]) v[63:32] = qd[0];
            else          v[31:0]  = qd[0];
            mem[blk] = v;
            $display("txn wr addr=%h data=%h", qa[0], qd[0]);
            void'(qa.pop_front());
            void'(qd.pop_front());
         end
         if (op == 1 && exp_ready) begin
            qa.push_back(req_addr);
            qd.push_back(req_wdata);
            release_req = 1'b1;
         end
         if (rd_done_now) release_req = 1'b1;
         wait_cnt++;
         if (op != 0 && !release_req && wait_cnt > 150) begin
            n_cmp++;
            n_err++;
            $display("FAIL rnd_timeout: request op=%0d not served after %0d cycles", op, wait_cnt);
            release_req = 1'b1;
         end
         tick();
         if (release_req) begin
            req_wr = 1'b0;
            req_rd = 1'b0;
            op     = 0;
         end
      end
      req_wr     = 1'b0;
      req_rd     = 1'b0;
      sram_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_full();
      test_read_bypass();
      test_read_conflict();
      test_ordering();
      test_random_traffic();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
